// File: rtl/ace_fetch_pkg.sv
// Shared constants, FSM encoding and address helper for the fetch packer.
package ace_fetch_pkg;

    localparam int FETCH_WIDTH = 8;
    localparam int LINE_BYTES  = 32;
    localparam int OFF_W       = 3;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] line_addr(input logic [31:0] pc);
        return {pc[31:5], 5'b0};
    endfunction

endpackage

// File: rtl/fetch_align.sv
// Shifts a fetched line down so the word at the PC offset lands in lane 0,
// and produces the matching per-lane valid mask.
module fetch_align
    import ace_fetch_pkg::*;
(
    input  logic [FETCH_WIDTH-1:0][31:0] i_line,
    input  logic [OFF_W-1:0]             i_off,
    output logic [FETCH_WIDTH-1:0][31:0] o_data,
    output logic [FETCH_WIDTH-1:0]       o_vld
);

    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
        logic [OFF_W:0] w_src;

        // Carry out of the source index means the lane runs past the line end.
        assign w_src     = (OFF_W+1)'(k) + {1'b0, i_off};
        assign o_vld[k]  = !w_src[OFF_W];
        assign o_data[k] = w_src[OFF_W] ? 32'h0 : i_line[w_src[OFF_W-1:0]];
    end

endmodule

// File: rtl/ace_fetch_pack.sv
// Fetch-side packet producer: PC, one-outstanding I-cache line requests, alignment
// and push into the decode buffer. ACE_FETCH_PERF_EN adds push/stall counters.
module ace_fetch_pack
    import ace_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         redirect_vld_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         ic_req_vld_o,
    input  logic         ic_req_rdy_i,
    output logic [31:0]  ic_req_addr_o,
    input  logic         ic_rsp_vld_i,
    input  logic [255:0] ic_rsp_data_i,
    input  logic         instbuf_full_i,
`ifdef ACE_FETCH_PERF_EN
    output logic [31:0]  perf_pkt_cnt_o,
    output logic [31:0]  perf_stall_cnt_o,
`endif
    output logic [255:0] fetch_inst_o,
    output logic [7:0]   fetch_vld_o
);

    fetch_state_e                 r_state;
    logic [31:0]                  r_pc;
    logic                         r_discard;
    logic [FETCH_WIDTH-1:0][31:0] r_hold;

    logic [FETCH_WIDTH-1:0][31:0] w_data;
    logic [FETCH_WIDTH-1:0]       w_mask;
    logic                         w_live;
    logic                         w_req_fire;
    logic                         w_push;

    // Redirect and reset both suppress every handshake in their cycle.
    assign w_live        = !reset && !redirect_vld_i;
    assign ic_req_vld_o  = w_live && (r_state == REQ) && !r_discard;
    assign ic_req_addr_o = line_addr(r_pc);
    assign w_req_fire    = ic_req_vld_o && ic_req_rdy_i;
    assign w_push        = w_live && (r_state == HOLD) && !instbuf_full_i;

    assign fetch_vld_o  = w_push ? w_mask : '0;
    assign fetch_inst_o = (w_live && (r_state == HOLD)) ? w_data : '0;

    fetch_align u_align (
        .i_line (r_hold),
        .i_off  (r_pc[4:2]),
        .o_data (w_data),
        .o_vld  (w_mask)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_state   <= REQ;
            r_discard <= 1'b0;
            r_hold    <= '0;
        end else if (redirect_vld_i) begin
            r_pc    <= redirect_pc_i;
            r_state <= REQ;
            r_hold  <= '0;
            // A response still owed to the old stream must be swallowed later,
            // unless it is arriving right now and dies with this redirect.
            r_discard <= (r_discard || (r_state == WAIT)) && !ic_rsp_vld_i;
        end else begin
            case (r_state)
                REQ: begin
                    if (r_discard) begin
                        if (ic_rsp_vld_i) r_discard <= 1'b0;
                    end else if (w_req_fire) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (ic_rsp_vld_i) begin
                        r_hold  <= ic_rsp_data_i;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!instbuf_full_i) begin
                        r_pc    <= line_addr(r_pc) + 32'(LINE_BYTES);
                        r_state <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase
        end
    end

`ifdef ACE_FETCH_PERF_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push) r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if ((r_state == HOLD) && instbuf_full_i) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_pkt_cnt_o   = r_pkt_cnt;
    assign perf_stall_cnt_o = r_stall_cnt;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ace_fetch_pack.sv
// Self-checking bench for ace_fetch_pack: I-cache model, push scoreboard,
// a vector table of redirect targets plus hand-written corner sequences.
module tb_ace_fetch_pack;

    logic         clock = 1'b0;
    logic         reset;
    logic         redirect_vld_i;
    logic [31:0]  redirect_pc_i;
    logic         ic_req_vld_o;
    logic         ic_req_rdy_i;
    logic [31:0]  ic_req_addr_o;
    logic         ic_rsp_vld_i;
    logic [255:0] ic_rsp_data_i;
    logic         instbuf_full_i;
    logic [255:0] fetch_inst_o;
    logic [7:0]   fetch_vld_o;
`ifdef ACE_FETCH_PERF_EN
    logic [31:0]  perf_pkt_cnt_o;
    logic [31:0]  perf_stall_cnt_o;
`endif

    ace_fetch_pack dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_vld_i (redirect_vld_i),
        .redirect_pc_i  (redirect_pc_i),
        .ic_req_vld_o   (ic_req_vld_o),
        .ic_req_rdy_i   (ic_req_rdy_i),
        .ic_req_addr_o  (ic_req_addr_o),
        .ic_rsp_vld_i   (ic_rsp_vld_i),
        .ic_rsp_data_i  (ic_rsp_data_i),
        .instbuf_full_i (instbuf_full_i),
`ifdef ACE_FETCH_PERF_EN
        .perf_pkt_cnt_o   (perf_pkt_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
        .fetch_inst_o   (fetch_inst_o),
        .fetch_vld_o    (fetch_vld_o)
    );

    always #5 clock = ~clock;

    typedef struct { logic [7:0] vld; logic [255:0] inst; } pkt_t;
    typedef struct { logic [31:0] addr; logic [2:0] off; int due; bit stale; } pend_t;
    typedef struct {
        logic [31:0] pc; int lat; int full;
        logic [31:0] addr; logic [7:0] vld; logic [31:0] nxt;
    } vec_t;

    int n_chk = 0, n_pass = 0;
    int cycle = 0, lat = 2, n_push = 0;
    pkt_t  exp_q[$];
    pend_t pend_q[$];
    logic [2:0] m_off = 3'd0;

    bit          cur_rsp = 0, cur_stale = 0;
    logic [2:0]  cur_off = 3'd0;
    logic [31:0] cur_addr = 32'd0;

    bit           acc_seen, push_seen, s_req_vld;
    logic [31:0]  s_req_addr, acc_addr;
    logic [7:0]   s_vld;
    logic [255:0] s_inst;
    int           acc_cyc, push_cyc, rsp_cyc;

    vec_t vt[6];

    function automatic logic [31:0] word_of(logic [31:0] line, int k);
        return (line + 32'(k * 4)) ^ 32'h5A00_00C3;
    endfunction

    function automatic logic [255:0] line_data(logic [31:0] line);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = word_of(line, k);
        return d;
    endfunction

    function automatic pkt_t expect_pkt(logic [31:0] line, logic [2:0] off);
        pkt_t p;
        p.vld  = '0;
        p.inst = '0;
        for (int k = 0; k < 8; k++)
            if (k < 8 - int'(off)) begin
                p.vld[k] = 1'b1;
                p.inst[32*k +: 32] = word_of(line, k + int'(off));
            end
        return p;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cycle);
    endtask

    task automatic chk_w(string name, logic [255:0] act, logic [255:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cycle);
    endtask

    // Observe the settled outputs of the current cycle (called at negedge).
    task automatic sample();
        pkt_t p;
        acc_seen   = 0;
        push_seen  = 0;
        s_req_vld  = ic_req_vld_o;
        s_req_addr = ic_req_addr_o;
        s_vld      = fetch_vld_o;
        s_inst     = fetch_inst_o;
        if (redirect_vld_i) chk("req_in_redirect", 32'(ic_req_vld_o), 32'd0);
        if (fetch_vld_o != 8'h0) begin
            push_seen = 1;
            push_cyc  = cycle;
            if (reset || redirect_vld_i || instbuf_full_i)
                chk("push_blocked", 32'(fetch_vld_o), 32'd0);
            else if (exp_q.size() == 0)
                chk("unexpected_push", 32'(fetch_vld_o), 32'd0);
            else begin
                p = exp_q.pop_front();
                chk("push_vld", 32'(fetch_vld_o), 32'(p.vld));
                chk_w("push_data", fetch_inst_o, p.inst);
                n_push++;
                m_off = 3'd0;
            end
        end
        if (reset) begin
            exp_q.delete();
            pend_q.delete();
            m_off  = 3'd0;
            n_push = 0;
        end else begin
            if (cur_rsp && !cur_stale && !redirect_vld_i) begin
                exp_q.push_back(expect_pkt(cur_addr, cur_off));
                rsp_cyc = cycle;
            end
            if (ic_req_vld_o && ic_req_rdy_i) begin
                acc_seen = 1;
                acc_addr = ic_req_addr_o;
                acc_cyc  = cycle;
                pend_q.push_back('{addr: ic_req_addr_o, off: m_off, due: cycle + lat, stale: 1'b0});
            end
            if (redirect_vld_i) begin
                foreach (pend_q[i]) pend_q[i].stale = 1'b1;
                m_off = redirect_pc_i[4:2];
            end
        end
    endtask

    // Sample this cycle, advance one clock, then drive any due I-cache response.
    task automatic cyc();
        pend_t e;
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
        cycle++;
        cur_rsp       = 0;
        ic_rsp_vld_i  = 1'b0;
        ic_rsp_data_i = '0;
        if (pend_q.size() > 0 && pend_q[0].due == cycle) begin
            e = pend_q.pop_front();
            ic_rsp_vld_i  = 1'b1;
            ic_rsp_data_i = line_data(e.addr);
            cur_rsp   = 1;
            cur_stale = e.stale;
            cur_off   = e.off;
            cur_addr  = e.addr;
        end
    endtask

    task automatic wait_acc(string name);
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (acc_seen) break;
        end
        chk(name, 32'(acc_seen), 32'd1);
    endtask

    task automatic wait_push(string name);
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (push_seen) break;
        end
        chk(name, 32'(push_seen), 32'd1);
    endtask

    task automatic run_vec(int idx);
        vec_t v;
        logic [31:0] stall0;
        v = vt[idx];
        stall0 = 32'd0;
        redirect_vld_i = 1'b1;
        redirect_pc_i  = v.pc;
        ic_req_rdy_i   = 1'b1;
        lat            = v.lat;
        cyc();
        redirect_vld_i = 1'b0;
        wait_acc("vec_acc");
        chk("vec_addr", acc_addr, v.addr);
        for (int i = 0; i < 20 && !(cur_rsp && !cur_stale); i++) cyc();
`ifdef ACE_FETCH_PERF_EN
        stall0 = perf_stall_cnt_o;
`endif
        cyc();
        instbuf_full_i = (v.full > 0);
        repeat (v.full) cyc();
        instbuf_full_i = 1'b0;
        wait_push("vec_push");
        chk("vec_vld", 32'(s_vld), 32'(v.vld));
        chk("vec_push_cycle", 32'(push_cyc - rsp_cyc), 32'(1 + v.full));
        ic_req_rdy_i = 1'b0;
        cyc();
        chk("vec_next_vld", 32'(s_req_vld), 32'd1);
        chk("vec_next_addr", s_req_addr, v.nxt);
`ifdef ACE_FETCH_PERF_EN
        chk("vec_stall_cnt", perf_stall_cnt_o - stall0, 32'(v.full));
`endif
        if (stall0 != 32'hFFFF_FFFF) stall0 = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{pc: 32'h8000_0014, lat: 2, full: 0, addr: 32'h8000_0000, vld: 8'h07, nxt: 32'h8000_0020};
        vt[1] = '{pc: 32'h8000_0018, lat: 1, full: 0, addr: 32'h8000_0000, vld: 8'h03, nxt: 32'h8000_0020};
        vt[2] = '{pc: 32'h1234_5670, lat: 3, full: 0, addr: 32'h1234_5660, vld: 8'h0F, nxt: 32'h1234_5680};
        vt[3] = '{pc: 32'hFFFF_FFE4, lat: 1, full: 0, addr: 32'hFFFF_FFE0, vld: 8'h7F, nxt: 32'h0000_0000};
        vt[4] = '{pc: 32'h4000_001C, lat: 2, full: 4, addr: 32'h4000_0000, vld: 8'h01, nxt: 32'h4000_0020};
        vt[5] = '{pc: 32'h2000_0000, lat: 1, full: 2, addr: 32'h2000_0000, vld: 8'hFF, nxt: 32'h2000_0020};

        reset          = 1'b1;
        redirect_vld_i = 1'b0;
        redirect_pc_i  = 32'd0;
        ic_req_rdy_i   = 1'b1;
        ic_rsp_vld_i   = 1'b0;
        ic_rsp_data_i  = '0;
        instbuf_full_i = 1'b0;
        lat            = 2;

        // Reset, first line fetch and the sequential follow-on line.
        cyc();
        cyc();
        chk("rst_req_vld", 32'(s_req_vld), 32'd0);
        chk("rst_fetch_vld", 32'(s_vld), 32'd0);
        chk_w("rst_fetch_inst", s_inst, '0);
        reset = 1'b0;
        cyc();
        chk("first_req_now", 32'(acc_seen), 32'd1);
        chk("first_req_addr", acc_addr, 32'h8000_0000);
        wait_push("first_push");
        chk("first_push_vld", 32'(s_vld), 32'hFF);
        chk("first_push_latency", 32'(push_cyc - acc_cyc), 32'd3);
        cyc();
        chk("second_req_now", 32'(acc_seen), 32'd1);
        chk("second_req_addr", acc_addr, 32'h8000_0020);
        chk("second_req_cycle", 32'(acc_cyc - push_cyc), 32'd1);
        wait_push("second_push");
        ic_req_rdy_i = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Redirect while waiting; stale response returns three cycles later.
        ic_req_rdy_i = 1'b1;
        lat          = 4;
        wait_acc("stale_setup_acc");
        redirect_vld_i = 1'b1;
        redirect_pc_i  = 32'h9000_0040;
        cyc();
        redirect_vld_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stale_no_req", 32'(s_req_vld), 32'd0);
        end
        cyc();
        chk("stale_resume_req", 32'(acc_seen), 32'd1);
        chk("stale_resume_addr", acc_addr, 32'h9000_0040);
        wait_push("stale_new_push");
        chk("stale_new_vld", 32'(s_vld), 32'hFF);
        ic_req_rdy_i = 1'b0;

        // Redirect in the same cycle as the response.
        ic_req_rdy_i = 1'b1;
        lat          = 2;
        wait_acc("same_setup_acc");
        cyc();
        redirect_vld_i = 1'b1;
        redirect_pc_i  = 32'hA000_0008;
        cyc();
        redirect_vld_i = 1'b0;
        cyc();
        chk("same_req_next", 32'(acc_seen), 32'd1);
        chk("same_req_addr", s_req_addr, 32'hA000_0000);
        wait_push("same_push");
        chk("same_push_vld", 32'(s_vld), 32'h3F);

        // Reset while holding a packet against a full buffer.
        lat = 1;
        wait_acc("rsthold_acc");
        for (int i = 0; i < 20 && !(cur_rsp && !cur_stale); i++) cyc();
        cyc();
        instbuf_full_i = 1'b1;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk("rsthold_vld", 32'(s_vld), 32'd0);
        chk("rsthold_req", 32'(s_req_vld), 32'd0);
        reset          = 1'b0;
        instbuf_full_i = 1'b0;
`ifdef ACE_FETCH_PERF_EN
        chk("rsthold_pkt_cnt", perf_pkt_cnt_o, 32'd0);
        chk("rsthold_stall_cnt", perf_stall_cnt_o, 32'd0);
`endif
        cyc();
        chk("rsthold_req_next", 32'(acc_seen), 32'd1);
        chk("rsthold_req_addr", acc_addr, 32'h8000_0000);
        wait_push("rsthold_push");
        chk("rsthold_push_vld", 32'(s_vld), 32'hFF);
        cyc();
`ifdef ACE_FETCH_PERF_EN
        chk("pkt_cnt_total", perf_pkt_cnt_o, 32'(n_push));
`endif
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
